bus_uart: RTL and testbench
===========================

// Module: bus_uart
// PURPOSE
//  Memory-mapped UART responder on the common memory bus, i.e. on the far side of the bus arbiter.
//  Decodes the bus address against BASE_ADDR and serialises written bytes through a TX FIFO.
//  Deserialises incoming bytes into a single-entry RX holding register.
//  Read data is combinational, so the arbiter's same-cycle ready is honoured.
//  Side effects (push, pop, clear) take effect on the clock edge.
// PARAMETERS
//  BASE_ADDR      32'h0001_0000  base of the 8-byte register window; bits [2:0] must be 0
//  CLK_DIV        434            clk cycles per bit (>=2); 16-bit counter
//  TX_FIFO_DEPTH  4              TX FIFO entries; a power of 2, >=2
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   asynchronous, active-low reset
//  address_in      in   32  bus address
//  read_in         in   1   bus read strobe
//  write_in        in   1   bus write strobe
//  read_value_out  out  32  read data; 32'b0 when not selected or not reading (OR-able)
//  write_mask_in   in   4   byte-lane enables
//  write_value_in  in   32  write data
//  tx_out          out  1   serial transmit line; idle high
//  rx_in           in   1   serial receive line; asynchronous to clk
// BEHAVIOUR
//  Reset: tx_out=1, FIFO empty, TX/RX FSMs IDLE, rx_valid=0, rx_overrun=0, read_value_out=0.
//  Select: sel = (address_in[31:3] == BASE_ADDR[31:3]). Bit 2 picks the register; bits [1:0] are ignored.
//  DATA register (+0):
//   - Write with sel & write_mask_in[0]: push write_value_in[7:0] if the FIFO is not full.
//     If the FIFO is full, the byte is silently dropped.
//   - Read: {23'b0, rx_valid, rx_data[7:0]}. A sel read clears rx_valid at the edge.
//  STATUS register (+4):
//   - Read: {28'b0, rx_overrun, rx_valid, tx_busy, tx_full}.
//   - Write with mask[0] & value[3]=1: clear rx_overrun. All other bits are read-only.
//  Read and write both set: perform both actions.
//  Push plus TX pop in the same cycle: the count is unchanged. Full/empty are judged on pre-edge state.
//  TX FSM (IDLE -> START -> DATA -> STOP -> IDLE):
//   - IDLE pops the head entry when the FIFO is non-empty.
//   - Each bit holds exactly CLK_DIV cycles. The baud counter loads CLK_DIV-1 and counts down to 0.
//   - Frame: start=0, 8 data bits LSB first, stop=1.
//   - STOP goes straight to START when the FIFO is non-empty, giving back-to-back frames with no idle gap.
//   - tx_busy = (state != IDLE) | !empty.
//  tx_out changes 1 cycle after the pop edge and is registered (no glitches).
//  RX: rx_in passes through a 2-flop synchroniser preset to 1.
//  RX FSM (IDLE -> START -> DATA -> STOP):
//   - IDLE: on a synchronised 0, wait CLK_DIV/2 cycles. Still 0 -> DATA; otherwise back to IDLE (glitch).
//   - DATA: sample 8 bits, each CLK_DIV cycles apart, LSB first.
//   - STOP: sample once more. 1 -> load rx_data, set rx_valid. 0 -> framing error: discard, no flags.
//  RX load rules:
//   - Load while rx_valid=1 overwrites rx_data and sets rx_overrun, unless a DATA read pops in the
//     same cycle; then there is no overrun and rx_valid stays 1.
//   - rx_overrun clear and new overrun in the same cycle: set wins.
//  Reset mid-frame: both FSMs return to IDLE at once; tx_out=1 asynchronously; FIFO contents are discarded.
// STRUCTURE
//  uart_pkg: register offset localparams (UART_DATA=3'h0, UART_STATUS=3'h4), STATUS bit indices,
//   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t, shared by TX and RX.
//  Sub-module uart_rx: synchroniser, RX FSM and baud counter. It outputs a byte plus a 1-cycle strobe.
//  TX FSM, FIFO, decode and the holding register stay in bus_uart.
// TESTING (bench uses CLK_DIV=4, TX_FIFO_DEPTH=4, BASE_ADDR=32'h0001_0000)
//  1. Reset, then write 0x0001_0000 value 0x55 mask 4'b0001.
//     -> tx_out: 4 cyc 0, then 1,0,1,0,1,0,1,0 (4 each), 4 cyc 1. tx_busy=1 through stop, then 0.
//  2. Write 6 bytes 0x01..0x06 back-to-back.
//     -> 0x01 is popped at once; 0x02..0x05 fill the FIFO; 0x06 is dropped.
//     -> tx_full=1 observed. 5 frames sent back-to-back, no idle gap.
//  3. Drive an rx_in frame carrying 0xA3.
//     -> after stop, STATUS bit2=1. DATA read returns 0x0000_01A3. Next STATUS read has bit2=0.
//  4. Send two RX frames (0x11, 0x22) without reading.
//     -> DATA=0x122, STATUS bit3=1. Write STATUS 0x8 -> bit3=0.
//  5. Pulse rx_in low for 1 cycle; separately, send a frame with stop=0.
//     -> no rx_valid, no overrun in either case.
//  6. Deassert reset_n mid-TX-frame.
//     -> tx_out=1 immediately; STATUS=0 after release. Read of 0x0002_0000 returns 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the frame state encoding used by both the TX and RX engines.
package uart_pkg;

    localparam logic [2:0] UART_DATA   = 3'h0;
    localparam logic [2:0] UART_STATUS = 3'h4;

    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_TX_BUSY    = 1;
    localparam int STAT_RX_VALID   = 2;
    localparam int STAT_RX_OVERRUN = 3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and baud counter.
// Emits the received byte with a one-cycle strobe on a good stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    output logic [7:0] rx_data_out,
    output logic       rx_strobe_out
);

    localparam logic [15:0] BIT_LOAD  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);

    logic        sync1_q, sync2_q;
    uart_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        ferr_q, ferr_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        ferr_d        = ferr_q;
        rx_strobe_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                ferr_d = 1'b0;
                if (!sync2_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: if (cnt_q == 16'd0) begin
                if (!sync2_q) begin
                    state_d = DATA;
                    cnt_d   = BIT_LOAD;
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (cnt_q == 16'd0) begin
                shift_d = {sync2_q, shift_q[7:1]};
                cnt_d   = BIT_LOAD;
                if (bit_q == 3'd7) state_d = STOP;
                else               bit_d   = bit_q + 3'd1;
            end
            STOP: if (cnt_q == 16'd0) begin
                // A low stop bit is discarded; wait for the line to idle so the tail is not a new start.
                if (sync2_q) begin
                    rx_strobe_out = !ferr_q;
                    state_d       = IDLE;
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data_out = shift_q;

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped UART on the shared bus: address decode, TX FIFO and serialiser,
// RX holding register with overrun tracking, combinational OR-able read data.
module bus_uart
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
    parameter int          CLK_DIV       = 434,
    parameter int          TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        read_in,
    input  logic        write_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        tx_out,
    input  logic        rx_in
);

    localparam int          PTR_W    = $clog2(TX_FIFO_DEPTH);
    localparam logic [15:0] BIT_LOAD = 16'(CLK_DIV - 1);

    logic sel, data_sel, status_sel, push, pop, data_rd, ovr_clr, full, empty, tx_busy;

    assign sel        = (address_in[31:3] == BASE_ADDR[31:3]);
    assign data_sel   = sel && (address_in[2] == UART_DATA[2]);
    assign status_sel = sel && (address_in[2] == UART_STATUS[2]);
    assign data_rd    = data_sel && read_in;
    assign ovr_clr    = status_sel && write_in && write_mask_in[0] && write_value_in[3];

    logic unused_bits;
    assign unused_bits = ^{address_in[1:0], write_mask_in[3:1], write_value_in[31:8], write_value_in[2:0]};

    logic [7:0]       fifo_q [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    assign full  = (count_q == (PTR_W + 1)'(TX_FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = data_sel && write_in && write_mask_in[0] && !full;

    // NOTE: the FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= write_value_in[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    uart_state_t tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q != 16'd0) ? tx_cnt_q - 16'd1 : tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                tx_shift_d = fifo_q[rd_ptr_q];
                tx_cnt_d   = BIT_LOAD;
                tx_state_d = START;
            end
            START: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d   = BIT_LOAD;
                tx_bit_d   = '0;
                tx_state_d = DATA;
            end
            DATA: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d   = BIT_LOAD;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                if (tx_bit_q == 3'd7) tx_state_d = STOP;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end
            STOP: if (tx_cnt_q == 16'd0) begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_q[rd_ptr_q];
                    tx_cnt_d   = BIT_LOAD;
                    tx_state_d = START;
                end else begin
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // The line level follows the current state and is registered, trailing the state by one cycle.
    always_comb begin
        unique case (tx_state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_out  = tx_q;
    assign tx_busy = (tx_state_q != IDLE) || !empty;

    logic [7:0] rx_byte, rx_data_q;
    logic       rx_strobe, rx_valid_q, rx_overrun_q;

    uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_in        (rx_in),
        .rx_data_out  (rx_byte),
        .rx_strobe_out(rx_strobe)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_strobe) begin
                rx_data_q  <= rx_byte;
                rx_valid_q <= 1'b1;
            end else if (data_rd) begin
                rx_valid_q <= 1'b0;
            end
            // A pop in the same cycle as the load consumes the old byte, so no overrun.
            if (rx_strobe && rx_valid_q && !data_rd) rx_overrun_q <= 1'b1;
            else if (ovr_clr)                        rx_overrun_q <= 1'b0;
        end
    end

    always_comb begin
        read_value_out = '0;
        if (sel && read_in) begin
            if (address_in[2] == UART_STATUS[2]) begin
                read_value_out[STAT_TX_FULL]    = full;
                read_value_out[STAT_TX_BUSY]    = tx_busy;
                read_value_out[STAT_RX_VALID]   = rx_valid_q;
                read_value_out[STAT_RX_OVERRUN] = rx_overrun_q;
            end else begin
                read_value_out[8:0] = {rx_valid_q, rx_data_q};
            end
        end
    end

endmodule

// File: tb/tb_bus_uart.sv
// Scoreboard bench for bus_uart: TX frames are decoded by a line monitor and
// compared against queued bytes; RX reads are compared against queued words.
module tb_bus_uart;

    localparam int          CLK_DIV = 4;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam logic [31:0] STAT    = 32'h0001_0004;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address_in = '0;
    logic        read_in = 1'b0;
    logic        write_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] write_value_in = '0;
    logic        tx_out;
    logic        rx_in = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [7:0]  tx_exp[$];
    logic [31:0] rx_exp[$];
    realtime     start_t[$];
    int          frames = 0;
    bit          rst_seen = 1'b0;

    bus_uart #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .TX_FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address_in    (address_in),
        .read_in       (read_in),
        .write_in      (write_in),
        .read_value_out(read_value_out),
        .write_mask_in (write_mask_in),
        .write_value_in(write_value_in),
        .tx_out        (tx_out),
        .rx_in         (rx_in)
    );

    always #5 clk = ~clk;

    always @(negedge reset_n) rst_seen = 1'b1;

    // Line monitor: samples each bit 1.5 cycles into its period and scores whole frames.
    always begin
        logic [7:0] got;
        logic       sb, pb;
        @(negedge tx_out);
        if (reset_n === 1'b1) begin
            start_t.push_back($realtime);
            rst_seen = 1'b0;
            repeat (2) @(negedge clk);
            sb = tx_out;
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                got[i] = tx_out;
            end
            repeat (CLK_DIV) @(negedge clk);
            pb = tx_out;
            if (!rst_seen) begin
                checks++;
                if (tx_exp.size() == 0) begin
                    failures++;
                    $display("FAIL tx_frame: unexpected frame byte=%02h", got);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = tx_exp.pop_front();
                    if ({sb, got, pb} !== {1'b0, exp_b, 1'b1}) begin
                        failures++;
                        $display("FAIL tx_frame: got start=%b byte=%02h stop=%b, want start=0 byte=%02h stop=1",
                                 sb, got, pb, exp_b);
                    end
                end
                frames++;
            end
        end
    end

    // All bus tasks start and end aligned to a falling clock edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val, input logic [3:0] mask);
        address_in = addr; write_value_in = val; write_mask_in = mask; write_in = 1'b1;
        @(negedge clk);
        write_in = 1'b0; write_mask_in = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val);
        address_in = addr; read_in = 1'b1;
        #1 val = read_value_out;
        @(negedge clk);
        read_in = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic wait_tx_low();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_out === 1'b0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL tx_start_timeout: tx_out=%b, want a start bit", tx_out); end
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 2000 && frames < n; i++) @(negedge clk);
        checks++;
        if (frames < n) begin failures++; $display("FAIL frame_timeout: frames=%0d, want %0d", frames, n); end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++;
        if (tx_out !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx_out); end
        checks++;
        if (read_value_out !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", read_value_out); end
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_status: got %h want 0", v); end
        bus_read(BASE, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", v); end
    endtask

    task automatic test_single_frame();
        logic [31:0] v;
        tx_exp.push_back(8'h55);
        bus_write(BASE, 32'h0000_0055, 4'b0001);
        bus_read(STAT, v);
        checks++;
        if (v[1] !== 1'b1) begin failures++; $display("FAIL busy_after_write: got %b want 1", v[1]); end
        wait_tx_low();
        repeat (36) @(negedge clk);
        bus_read(STAT, v);
        checks++;
        if (v[1] !== 1'b1) begin failures++; $display("FAIL busy_in_stop: got %b want 1", v[1]); end
        repeat (2) @(negedge clk);
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL idle_status: got %h want 0", v); end
        wait_frames(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int base, f0;
        base = start_t.size();
        f0   = frames;
        // 0x01 is popped straight away and 0x02..0x05 fill the FIFO, so 0x06 is dropped.
        for (int b = 1; b <= 5; b++) tx_exp.push_back(8'(b));
        for (int b = 1; b <= 6; b++) bus_write(BASE, 32'(b), 4'b0001);
        bus_read(STAT, v);
        checks++;
        if (v[0] !== 1'b1) begin failures++; $display("FAIL tx_full: got %b want 1", v[0]); end
        wait_frames(f0 + 5);
        checks++;
        if (start_t.size() - base !== 5) begin
            failures++; $display("FAIL b2b_count: got %0d starts want 5", start_t.size() - base);
        end else begin
            for (int i = base + 1; i < start_t.size(); i++) begin
                checks++;
                if (start_t[i] - start_t[i-1] != 10.0 * CLK_DIV * 10) begin
                    failures++;
                    $display("FAIL b2b_gap: got spacing %0t want %0d", start_t[i] - start_t[i-1], 10 * CLK_DIV * 10);
                end
            end
        end
        repeat (60) @(negedge clk);
        checks++;
        if (frames !== f0 + 5 || tx_exp.size() != 0) begin
            failures++; $display("FAIL b2b_drop: got %0d frames, %0d pending; want 5, 0", frames - f0, tx_exp.size());
        end
    endtask

    task automatic test_rx_basic();
        logic [31:0] v;
        rx_exp.push_back(32'h0000_01A3);
        send_rx(8'hA3, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h4) begin failures++; $display("FAIL rx_valid_status: got %h want 4", v); end
        bus_read(BASE, v);
        checks++;
        if (v !== rx_exp[0]) begin failures++; $display("FAIL rx_data: got %h want %h", v, rx_exp[0]); end
        void'(rx_exp.pop_front());
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rx_valid_clear: got %h want 0", v); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] v;
        rx_exp.push_back(32'h0000_0122);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(STAT, v);
        checks++;
        if (v !== 32'hC) begin failures++; $display("FAIL overrun_status: got %h want c", v); end
        bus_read(BASE, v);
        checks++;
        if (v !== rx_exp[0]) begin failures++; $display("FAIL overrun_data: got %h want %h", v, rx_exp[0]); end
        void'(rx_exp.pop_front());
        bus_write(STAT, 32'h8, 4'b0001);
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL overrun_clear: got %h want 0", v); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] v;
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rx_glitch: got %h want 0", v); end
        send_rx(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rx_framing: got %h want 0", v); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        int f0;
        bit went_low = 1'b0;
        f0 = frames;
        bus_write(BASE, 32'h0000_000F, 4'b0001);
        wait_tx_low();
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b0) begin failures++; $display("FAIL pre_reset_tx: got %b want 0", tx_out); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1) begin failures++; $display("FAIL async_reset_tx: got %b want 1", tx_out); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(STAT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL post_reset_status: got %h want 0", v); end
        bus_read(32'h0002_0000, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL unselected_read: got %h want 0", v); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) went_low = 1'b1;
        end
        checks++;
        if (went_low || frames != f0) begin
            failures++; $display("FAIL fifo_discard: got line activity=%b frames=%0d want 0, %0d", went_low, frames, f0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_rx_basic();
        test_rx_overrun();
        test_rx_errors();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
